// File: rtl/uart_host_pkg.sv
// Shared constants and state types for the UART host bridge.
package uart_host_pkg;

   // Frame opcodes sent by the host.
   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;

   // Reply bytes returned to the host.
   localparam logic [7:0] REPLY_ACK = 8'h06;
   localparam logic [7:0] REPLY_NAK = 8'h15;

   // A transmit FIFO holding this many bytes is treated as full.
   localparam logic [10:0] TX_FIFO_LIMIT = 11'd1023;

   // Main command FSM.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_A1,
      ST_GET_A0,
      ST_GET_D,
      ST_MEM,
      ST_SEND
   } host_state_e;

   // Receive-side read sequencing.
   typedef enum logic [1:0] {
      RD_IDLE,
      RD_HIGH,
      RD_GAP
   } rd_state_e;

   // Transmit-side write handshake.
   typedef enum logic {
      WR_IDLE,
      WR_HOLD
   } wr_state_e;

   // True for the opcodes that start a multi-byte frame.
   function automatic logic is_frame_opcode(input logic [7:0] op);
      return (op == OP_WRITE) || (op == OP_READ);
   endfunction

endpackage

// File: rtl/uart_byte_port.sv
// Byte-level adapter to uart_min: paced reads from the RX FIFO and
// pulse_en-qualified writes into the TX FIFO.
module uart_byte_port
   import uart_host_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        pulse_en,
   // fetch side
   input  logic        get_req,
   output logic        get_done,
   output logic [7:0]  get_byte,
   // send side
   input  logic        put_req,
   input  logic [7:0]  put_byte,
   output logic        put_done,
   // uart_min
   output logic        uart_read,
   output logic        uart_write,
   output logic [7:0]  uart_wdata,
   input  logic [7:0]  uart_rdata,
   input  logic [10:0] uart_rx_count,
   input  logic [10:0] uart_tx_count
);

   rd_state_e   rd_state_q, rd_state_d;
   logic [1:0]  rd_cnt_q, rd_cnt_d;
   logic        uart_read_q, uart_read_d;
   wr_state_e   wr_state_q, wr_state_d;
   logic        uart_write_q, uart_write_d;
   logic [7:0]  uart_wdata_q, uart_wdata_d;

   // The byte is taken on the third edge with read high, which is also the
   // edge that drops read; the consumer captures uart_rdata on that edge.
   assign get_done = (rd_state_q == RD_HIGH) && (rd_cnt_q == 2'd2);
   assign get_byte = uart_rdata;

   // The accepting edge is the one where write is high and pulse_en is high.
   assign put_done = (wr_state_q == WR_HOLD) && pulse_en;

   assign uart_read  = uart_read_q;
   assign uart_write = uart_write_q;
   assign uart_wdata = uart_wdata_q;

   // Next-state logic for read pacing (3 high, >=2 low) and write handshake.
   always_comb begin
      // NOTE: every signal gets its hold value first so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      rd_state_d   = rd_state_q;
      rd_cnt_d     = rd_cnt_q;
      uart_read_d  = uart_read_q;
      wr_state_d   = wr_state_q;
      uart_write_d = uart_write_q;
      uart_wdata_d = uart_wdata_q;

      case (rd_state_q)
         RD_IDLE: begin
            if (get_req && (uart_rx_count != 11'd0)) begin
               rd_state_d  = RD_HIGH;
               rd_cnt_d    = 2'd0;
               uart_read_d = 1'b1;
            end
         end
         RD_HIGH: begin
            if (rd_cnt_q == 2'd2) begin
               rd_state_d  = RD_GAP;
               uart_read_d = 1'b0;
            end else begin
               rd_cnt_d = rd_cnt_q + 2'd1;
            end
         end
         // One cycle here plus one in RD_IDLE gives the two low cycles the
         // UART read FSM needs before rx_count is trustworthy again.
         RD_GAP:  rd_state_d = RD_IDLE;
         default: rd_state_d = RD_IDLE;
      endcase

      case (wr_state_q)
         WR_IDLE: begin
            if (put_req && (uart_tx_count < TX_FIFO_LIMIT)) begin
               wr_state_d   = WR_HOLD;
               uart_write_d = 1'b1;
               uart_wdata_d = put_byte;
            end
         end
         WR_HOLD: begin
            if (pulse_en) begin
               wr_state_d   = WR_IDLE;
               uart_write_d = 1'b0;
               uart_wdata_d = 8'h00;
            end
         end
         default: wr_state_d = WR_IDLE;
      endcase
   end

   // Port registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order or process scheduling.
      if (!reset) begin
         rd_state_q   <= RD_IDLE;
         rd_cnt_q     <= 2'd0;
         uart_read_q  <= 1'b0;
         wr_state_q   <= WR_IDLE;
         uart_write_q <= 1'b0;
         uart_wdata_q <= 8'h00;
      end else begin
         rd_state_q   <= rd_state_d;
         rd_cnt_q     <= rd_cnt_d;
         uart_read_q  <= uart_read_d;
         wr_state_q   <= wr_state_d;
         uart_write_q <= uart_write_d;
         uart_wdata_q <= uart_wdata_d;
      end
   end

endmodule

// File: rtl/uart_host_bridge.sv
// Host command bridge: parses W/R frames from uart_min, performs one memory
// access per frame and returns ACK, read data or NAK.
module uart_host_bridge
   import uart_host_pkg::*;
#(
   parameter int ADDR_WIDTH  = 16,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  pulse_en,
   output logic                  uart_read,
   output logic                  uart_write,
   output logic [7:0]            uart_wdata,
   input  logic [7:0]            uart_rdata,
   input  logic [10:0]           uart_rx_count,
   input  logic [10:0]           uart_tx_count,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [7:0]            mem_wdata,
   output logic                  mem_we,
   output logic                  mem_re,
   input  logic [7:0]            mem_rdata,
   input  logic                  mem_ready,
   output logic                  busy,
   output logic [7:0]            err_count
);

   // Timer counts strobe cycles 0..MEM_TIMEOUT-1; abort on the last one.
   localparam int TIMER_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(MEM_TIMEOUT - 1);

   host_state_e            state_q, state_d;
   logic                   is_write_q, is_write_d;
   logic [7:0]             a1_q, a1_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [7:0]             wdata_q, wdata_d;
   logic                   mem_we_q, mem_we_d;
   logic                   mem_re_q, mem_re_d;
   logic [TIMER_W-1:0]     timer_q, timer_d;
   logic [7:0]             reply_q, reply_d;
   logic                   nak_q, nak_d;
   logic                   busy_q, busy_d;
   logic [7:0]             err_count_q, err_count_d;

   logic                   get_req, get_done;
   logic [7:0]             get_byte;
   logic                   put_req, put_done;

   // Fetch while parsing a frame, send while holding a reply.
   assign get_req = (state_q == ST_IDLE)   || (state_q == ST_GET_A1) ||
                    (state_q == ST_GET_A0) || (state_q == ST_GET_D);
   assign put_req = (state_q == ST_SEND);

   uart_byte_port u_port (
      .clock         (clock),
      .reset         (reset),
      .pulse_en      (pulse_en),
      .get_req       (get_req),
      .get_done      (get_done),
      .get_byte      (get_byte),
      .put_req       (put_req),
      .put_byte      (reply_q),
      .put_done      (put_done),
      .uart_read     (uart_read),
      .uart_write    (uart_write),
      .uart_wdata    (uart_wdata),
      .uart_rdata    (uart_rdata),
      .uart_rx_count (uart_rx_count),
      .uart_tx_count (uart_tx_count)
   );

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_we    = mem_we_q;
   assign mem_re    = mem_re_q;
   assign busy      = busy_q;
   assign err_count = err_count_q;

   // Frame parser, memory access with timeout, and reply/error bookkeeping.
   always_comb begin
      state_d     = state_q;
      is_write_d  = is_write_q;
      a1_d        = a1_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      mem_we_d    = mem_we_q;
      mem_re_d    = mem_re_q;
      timer_d     = timer_q;
      reply_d     = reply_q;
      nak_d       = nak_q;
      err_count_d = err_count_q;

      case (state_q)
         ST_IDLE: begin
            if (get_done) begin
               if (is_frame_opcode(get_byte)) begin
                  is_write_d = (get_byte == OP_WRITE);
                  state_d    = ST_GET_A1;
               end else begin
                  // Unknown opcode: reply at once, consume nothing more.
                  reply_d = REPLY_NAK;
                  nak_d   = 1'b1;
                  state_d = ST_SEND;
               end
            end
         end
         ST_GET_A1: begin
            if (get_done) begin
               a1_d    = get_byte;
               state_d = ST_GET_A0;
            end
         end
         ST_GET_A0: begin
            if (get_done) begin
               // Big-endian 16-bit frame address, fitted to ADDR_WIDTH.
               addr_d  = ADDR_WIDTH'({a1_q, get_byte});
               state_d = is_write_q ? ST_GET_D : ST_MEM;
            end
         end
         ST_GET_D: begin
            if (get_done) begin
               wdata_d = get_byte;
               state_d = ST_MEM;
            end
         end
         ST_MEM: begin
            if (!mem_we_q && !mem_re_q) begin
               // First cycle in MEM: raise the strobe; ready is ignored here.
               mem_we_d = is_write_q;
               mem_re_d = !is_write_q;
               timer_d  = '0;
            end else if (mem_ready) begin
               mem_we_d = 1'b0;
               mem_re_d = 1'b0;
               reply_d  = is_write_q ? REPLY_ACK : mem_rdata;
               nak_d    = 1'b0;
               state_d  = ST_SEND;
            end else if (timer_q == TIMER_LAST) begin
               mem_we_d = 1'b0;
               mem_re_d = 1'b0;
               reply_d  = REPLY_NAK;
               nak_d    = 1'b1;
               state_d  = ST_SEND;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_SEND: begin
            if (put_done) begin
               state_d = ST_IDLE;
               // A read returning 0x15 is data, so count only flagged NAKs.
               if (nak_q && (err_count_q != 8'hFF)) begin
                  err_count_d = err_count_q + 8'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // Bridge registers; reset discards any partial frame and drops strobes.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         is_write_q  <= 1'b0;
         a1_q        <= 8'h00;
         addr_q      <= '0;
         wdata_q     <= 8'h00;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         timer_q     <= '0;
         reply_q     <= 8'h00;
         nak_q       <= 1'b0;
         busy_q      <= 1'b0;
         err_count_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         is_write_q  <= is_write_d;
         a1_q        <= a1_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         mem_we_q    <= mem_we_d;
         mem_re_q    <= mem_re_d;
         timer_q     <= timer_d;
         reply_q     <= reply_d;
         nak_q       <= nak_d;
         busy_q      <= busy_d;
         err_count_q <= err_count_d;
      end
   end

endmodule

// File: tb/tb_uart_host_bridge.sv
// Self-checking bench for uart_host_bridge: UART FIFO and memory models,
// frame-level reference model, directed and randomized frames.
module tb_uart_host_bridge;

   localparam int ADDR_WIDTH  = 16;
   localparam int MEM_TIMEOUT = 255;

   logic                  clock;
   logic                  reset;
   logic                  pulse_en;
   logic                  uart_read;
   logic                  uart_write;
   logic [7:0]            uart_wdata;
   logic [7:0]            uart_rdata;
   logic [10:0]           uart_rx_count;
   logic [10:0]           uart_tx_count;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [7:0]            mem_wdata;
   logic                  mem_we;
   logic                  mem_re;
   logic [7:0]            mem_rdata;
   logic                  mem_ready;
   logic                  busy;
   logic [7:0]            err_count;

   uart_host_bridge #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clock         (clock),
      .reset         (reset),
      .pulse_en      (pulse_en),
      .uart_read     (uart_read),
      .uart_write    (uart_write),
      .uart_wdata    (uart_wdata),
      .uart_rdata    (uart_rdata),
      .uart_rx_count (uart_rx_count),
      .uart_tx_count (uart_tx_count),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_we        (mem_we),
      .mem_re        (mem_re),
      .mem_rdata     (mem_rdata),
      .mem_ready     (mem_ready),
      .busy          (busy),
      .err_count     (err_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  data;
   } txn_t;

   int checks   = 0;
   int failures = 0;

   // Environment state.
   logic [7:0] rx_q[$];
   logic [7:0] tx_obs[$];
   txn_t       txn_obs[$];
   int         strobe_len_obs[$];
   logic [7:0] dev_mem[logic [15:0]];
   int         mem_lat     = 0;
   int         pulse_div   = 1;
   bit         ready_noise = 0;
   int         cyc         = 0;
   int         rd_run      = 0;
   int         rd_gap      = 0;
   bit         rd_seen_fall = 0;
   int         strobe_run  = 0;
   bit         bp_viol     = 0;
   bit         both_viol   = 0;

   // Reference model state.
   logic [7:0] ref_mem[logic [15:0]];
   logic [7:0] exp_tx[$];
   txn_t       txn_exp[$];
   int         strobe_len_exp[$];
   int         exp_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] init_val(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic logic [7:0] ref_val(input logic [15:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   // UART RX FIFO, read-pacing monitor, memory responder and pulse_en source.
   initial begin
      uart_rx_count = 11'd0;
      uart_rdata    = 8'h00;
      mem_ready     = 1'b0;
      mem_rdata     = 8'h00;
      pulse_en      = 1'b0;
      forever begin
         @(negedge clock);
         if (uart_read) begin
            if (rd_run == 0 && rd_seen_fall) check("rd_gap_min2", 32'(rd_gap >= 2), 1);
            rd_run++;
         end else begin
            if (rd_run > 0) begin
               check("rd_high_len", rd_run, 3);
               if (rx_q.size() > 0) void'(rx_q.pop_front());
               rd_gap = 1;
               rd_seen_fall = 1;
            end else begin
               rd_gap++;
            end
            rd_run = 0;
         end
         uart_rx_count = 11'(rx_q.size());
         uart_rdata    = (rx_q.size() > 0) ? rx_q[0] : 8'h00;

         if (mem_we && mem_re) both_viol = 1;
         if (mem_we || mem_re) begin
            if (strobe_run == 0) begin
               txn_t t;
               t.we   = mem_we;
               t.addr = mem_addr;
               t.data = mem_wdata;
               txn_obs.push_back(t);
            end
            mem_ready = (mem_lat >= 0) && (strobe_run >= mem_lat);
            strobe_run++;
         end else begin
            if (strobe_run > 0) strobe_len_obs.push_back(strobe_run);
            strobe_run = 0;
            mem_ready = ready_noise ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         mem_rdata = dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : init_val(mem_addr);

         pulse_en = ((cyc % pulse_div) == 0);
         cyc++;
      end
   end

   // Edge-sampled events: accepted TX bytes, memory writes, full-FIFO writes.
   initial begin
      forever begin
         @(posedge clock);
         if (uart_write && pulse_en) tx_obs.push_back(uart_wdata);
         if (uart_write && uart_tx_count >= 11'd1023) bp_viol = 1;
         if (mem_we && mem_ready) dev_mem[mem_addr] = mem_wdata;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic model_nak();
      exp_tx.push_back(8'h15);
      if (exp_err < 255) exp_err++;
   endtask

   // Frame-level reference: what a host should see for a byte stream.
   task automatic model_stream(input logic [7:0] b[$]);
      int   i = 0;
      txn_t t;
      while (i < b.size()) begin
         if (b[i] == 8'h57 || b[i] == 8'h52) begin
            t.we   = (b[i] == 8'h57);
            t.addr = {b[i+1], b[i+2]};
            t.data = t.we ? b[i+3] : 8'h00;
            txn_exp.push_back(t);
            if (mem_lat < 0) begin
               strobe_len_exp.push_back(MEM_TIMEOUT);
               model_nak();
            end else begin
               strobe_len_exp.push_back(mem_lat + 1);
               if (t.we) begin
                  ref_mem[t.addr] = t.data;
                  exp_tx.push_back(8'h06);
               end else begin
                  exp_tx.push_back(ref_val(t.addr));
               end
            end
            i += t.we ? 4 : 3;
         end else begin
            model_nak();
            i += 1;
         end
      end
   endtask

   task automatic push_stream(input logic [7:0] b[$]);
      model_stream(b);
      foreach (b[k]) rx_q.push_back(b[k]);
   endtask

   task automatic clear_all();
      tx_obs.delete();
      txn_obs.delete();
      strobe_len_obs.delete();
      exp_tx.delete();
      txn_exp.delete();
      strobe_len_exp.delete();
   endtask

   task automatic finish_stream(input string tag, input int budget);
      int n = 0;
      while ((tx_obs.size() < exp_tx.size() || busy || rx_q.size() != 0) && n < budget) begin
         tick(1);
         n++;
      end
      check({tag, "_in_budget"}, 32'(n < budget), 1);
      tick(4);
      check({tag, "_reply_count"}, tx_obs.size(), exp_tx.size());
      for (int i = 0; i < exp_tx.size() && i < tx_obs.size(); i++)
         check({tag, "_reply"}, tx_obs[i], exp_tx[i]);
      check({tag, "_txn_count"}, txn_obs.size(), txn_exp.size());
      for (int i = 0; i < txn_exp.size() && i < txn_obs.size(); i++) begin
         check({tag, "_txn_we"}, txn_obs[i].we, txn_exp[i].we);
         check({tag, "_txn_addr"}, txn_obs[i].addr, txn_exp[i].addr);
         if (txn_exp[i].we) check({tag, "_txn_wdata"}, txn_obs[i].data, txn_exp[i].data);
      end
      check({tag, "_strobe_count"}, strobe_len_obs.size(), strobe_len_exp.size());
      for (int i = 0; i < strobe_len_exp.size() && i < strobe_len_obs.size(); i++)
         check({tag, "_strobe_len"}, strobe_len_obs[i], strobe_len_exp[i]);
      check({tag, "_err_count"}, err_count, exp_err);
      check({tag, "_busy_idle"}, busy, 0);
      clear_all();
   endtask

   initial begin
      logic [7:0] s[$];
      logic [7:0] op;
      int         n;

      reset         = 1'b0;
      uart_tx_count = 11'd0;
      tick(3);
      check("reset_ctrl_outputs",
            {11'd0, uart_read, uart_write, uart_wdata, mem_we, mem_re, busy, err_count}, 0);
      check("reset_mem_addr", mem_addr, 0);
      check("reset_mem_wdata", mem_wdata, 0);
      reset = 1'b1;
      tick(2);

      // Write with a 2-cycle memory.
      mem_lat = 2; pulse_div = 1;
      s = {8'h57, 8'h12, 8'h34, 8'hA5};
      push_stream(s);
      finish_stream("write", 400);
      check("write_mem_content", dev_mem.exists(16'h1234) ? dev_mem[16'h1234] : 8'h00, 8'hA5);

      // Read returning 0x3C.
      dev_mem[16'h0010] = 8'h3C;
      ref_mem[16'h0010] = 8'h3C;
      mem_lat = 1;
      s = {8'h52, 8'h00, 8'h10};
      push_stream(s);
      finish_stream("read", 400);

      // Bad opcode immediately followed by a read frame.
      mem_lat = 0;
      s = {8'h41, 8'h52, 8'h00, 8'h10};
      push_stream(s);
      finish_stream("badop_then_read", 400);

      // Memory never ready.
      mem_lat = -1;
      s = {8'h57, 8'hAB, 8'hCD, 8'hEF};
      push_stream(s);
      finish_stream("timeout", 1000);
      check("timeout_no_write", dev_mem.exists(16'hABCD), 0);

      // TX FIFO full during SEND, pulse_en every 4th cycle.
      mem_lat = 1; pulse_div = 4;
      uart_tx_count = 11'd1023;
      s = {8'h52, 8'h00, 8'h10};
      push_stream(s);
      tick(80);
      check("bp_no_byte_while_full", tx_obs.size(), 0);
      check("bp_write_low_while_full", uart_write, 0);
      check("bp_busy_while_full", busy, 1);
      uart_tx_count = 11'd1022;
      finish_stream("backpressure", 400);
      uart_tx_count = 11'd0;

      // Randomized frames, spurious mem_ready between accesses.
      ready_noise = 1;
      for (int f = 0; f < 24; f++) begin
         mem_lat       = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
         pulse_div     = $urandom_range(1, 4);
         uart_tx_count = 11'($urandom_range(0, 1022));
         case ($urandom_range(0, 4))
            0, 1: s = {8'h57, 8'($urandom), 8'($urandom), 8'($urandom)};
            2, 3: s = {8'h52, 8'($urandom), 8'($urandom)};
            default: begin
               op = 8'($urandom);
               while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
               s = {op};
            end
         endcase
         push_stream(s);
         finish_stream("random", 1500);
      end
      ready_noise   = 0;
      uart_tx_count = 11'd0;

      // 256 back-to-back NAKs saturate the error counter.
      mem_lat = 0; pulse_div = 1;
      s = {};
      for (int k = 0; k < 256; k++) begin
         op = 8'($urandom);
         while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
         s.push_back(op);
      end
      push_stream(s);
      finish_stream("saturate", 12000);
      check("saturate_err_255", err_count, 8'hFF);

      // Reset in the middle of a write strobe.
      mem_lat = -1;
      s = {8'h57, 8'h12, 8'h34, 8'h56};
      foreach (s[k]) rx_q.push_back(s[k]);
      n = 0;
      while (!mem_we && n < 200) begin
         tick(1);
         n++;
      end
      check("rst_we_seen", mem_we, 1);
      tick(5);
      reset = 1'b0;
      tick(1);
      check("rst_ctrl_outputs",
            {11'd0, uart_read, uart_write, uart_wdata, mem_we, mem_re, busy, err_count}, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      reset = 1'b1;
      tick(2);
      rx_q.delete();
      clear_all();
      exp_err = 0;
      mem_lat = 1;
      s = {8'h57, 8'h00, 8'h01, 8'hFF};
      push_stream(s);
      finish_stream("after_reset", 400);
      check("after_reset_mem", dev_mem.exists(16'h0001) ? dev_mem[16'h0001] : 8'h00, 8'hFF);

      check("bp_never_write_when_full", bp_viol, 0);
      check("strobes_exclusive", both_viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_host_bridge.md
# uart_host_bridge

Serial debug/loader bridge sitting on the processor side of `uart_min`: it drains received bytes, parses fixed-length command frames, performs single-byte memory reads and writes on a simple request/ready bus, and returns an ACK, data or NAK byte through the UART transmit path. It lets a host PC inspect and load memory over the 115200-baud link without processor involvement.

## Interface
- `ADDR_WIDTH`, 16: memory address width; the frame carries exactly 2 address bytes, big-endian, truncated/zero-extended to this width.
- `MEM_TIMEOUT`, 255: cycles to wait for `mem_ready` before aborting with NAK.
- `clock`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-low reset (integration inverts it for `uart_min`, whose reset is active-high).
- `pulse_en`  in  1  same write-qualify strobe fed to `uart_min`.
- `uart_read`  out  1  to `uart_min.read`.
- `uart_write`  out  1  to `uart_min.write`.
- `uart_wdata`  out  8  to `uart_min.data_in`.
- `uart_rdata`  in  8  from `uart_min.data_out`.
- `uart_rx_count`  in  11  from `uart_min.rx_count`.
- `uart_tx_count`  in  11  from `uart_min.tx_count`.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_wdata`  out  8  write data.
- `mem_we` / `mem_re`  out  1 each  request strobes, held until ready or timeout.
- `mem_rdata`  in  8  read data, valid when `mem_ready`.
- `mem_ready`  in  1  completion.
- `busy`  out  1  high whenever FSM is not in `IDLE`.
- `err_count`  out  8  saturating count of NAKs sent.

## Operation
- Frames: `0x57` ('W') A1 A0 D -> write D to {A1,A0}, reply `0x06`. `0x52` ('R') A1 A0 -> read, reply data byte. Any other opcode -> reply `0x15`, no further bytes consumed.
- Main FSM: `IDLE` (fetch opcode) -> `GET_A1` -> `GET_A0` -> (`GET_D` if W) -> `MEM` -> `SEND` -> `IDLE`. Bad opcode: `IDLE` -> `SEND` (NAK).
- `MEM`: assert `mem_we` or `mem_re` with stable addr/data; on `mem_ready` sampled high, drop strobe next cycle, latch `mem_rdata` on reads. After `MEM_TIMEOUT` cycles without ready: drop strobe, send NAK.
- Every NAK increments `err_count`, saturating at 255.
- Byte fetch (sub-module): wait until `uart_rx_count != 0`; hold `uart_read` high exactly 3 cycles; capture `uart_rdata` on the 3rd edge; hold `uart_read` low at least 2 cycles before the next fetch (lets the UART read FSM return to idle and `rx_count` settle).
- Byte send: wait until `uart_tx_count < 1023` (no-full FIFO, never overfill); drive `uart_wdata`, raise `uart_write`, hold until an edge where `pulse_en` is high, drop on the following cycle. Exactly one `pulse_en`-qualified cycle with write high per byte.
- No inter-byte timeout: a partial frame waits indefinitely; only `reset` clears it.

## Timing
- Reset (`reset`=0 at edge): FSM `IDLE`, all outputs 0, `err_count` 0; an in-flight memory strobe or UART read/write drops on that same edge, the partial frame is discarded.
- Min byte-fetch period 5 cycles; opcode to memory strobe >= 15 cycles for W (4 fetches).
- Memory strobe rises the cycle after entering `MEM`; `mem_ready` in the same cycle as the strobe's first cycle is legal (1-cycle access).
- `busy` drops on the edge where the reply byte is accepted (write dropped) and FSM returns to `IDLE`.
- `mem_ready` while no strobe is active: ignored.

## Structure
- Package `uart_host_pkg`: opcode constants (`0x57`, `0x52`), reply constants (`0x06`, `0x15`), FSM state enum, `TX_FIFO_LIMIT` = 1023.
- Sub-module `uart_byte_port`: owns the 3-high/2-low read sequencing and the `pulse_en`-qualified write handshake; exposes `get_req/get_done/get_byte` and `put_req/put_done/put_byte` to the main FSM.

## Test plan
- Write: rx bytes 57 12 34 A5, `mem_ready` 2 cycles after `mem_we` -> one write addr 0x1234 data 0xA5; exactly one 0x06 enqueued; `err_count` 0.
- Read: rx 52 00 10, memory returns 0x3C -> `mem_re` addr 0x0010, reply 0x3C; `uart_read` each time high exactly 3 cycles, gaps >= 2.
- Bad opcode 0x41 followed by 52 00 10 -> NAK 0x15, `err_count`=1, then the read completes normally.
- Timeout: W frame, `mem_ready` never asserted -> strobe drops after 255 cycles, 0x15 sent, `err_count` +1; 256 NAKs -> saturates at 255.
- Backpressure: `uart_tx_count`=1023 during `SEND` -> `uart_write` stays 0 until count 1022; `pulse_en` every 4th cycle -> write held until qualified, one byte only.
- Reset asserted mid-`MEM` with `mem_we` high -> all outputs 0 next cycle, subsequent frame 57 00 01 FF processes correctly.
